// File: rtl/mac_tcdm_responder_pkg.sv
// Shared constants and monitor types for the MAC subsystem TCDM responder.
package mac_tcdm_responder_pkg;

  localparam logic [31:0] MAC_TCDM_RESP_ERR_DATA  = 32'hBAD0_BAD0;
  localparam logic [15:0] MAC_TCDM_RESP_LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic        err;
  } flags_tcdm_resp_t;

endpackage

// File: rtl/mac_tcdm_responder_if.sv
// TCDM request/response bundle between the MAC streamer (master) and a memory target (slave).
interface mac_tcdm_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic [31:0]             add;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data;
  logic                    gnt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/mac_tcdm_responder_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable and synchronous reseed.
module mac_tcdm_resp_lfsr
  import mac_tcdm_responder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clear_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d = lfsr_q;
    if (clear_i)   lfsr_d = MAC_TCDM_RESP_LFSR_SEED;
    else if (en_i) lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= MAC_TCDM_RESP_LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mac_tcdm_responder.sv
// Word-addressed TCDM target with programmable grant wait and one-cycle response.
// Define MAC_TCDM_RESP_RANDOM_STALL_EN to add up to 3 LFSR-driven extra wait cycles.
module mac_tcdm_responder
  import mac_tcdm_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_WORDS   = 1024,
  parameter int unsigned STALL_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  mac_tcdm_responder_if.slave  tcdm_slv,
  input  logic [STALL_W-1:0]   stall_cycles_i,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o,
  output logic                 err_o
);

  localparam int unsigned AW  = $clog2(NB_WORDS);
  localparam int unsigned NBE = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];

  logic [STALL_W-1:0]    sc_q, sc_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic                  gnt, acc, oor;
  logic [AW-1:0]         idx;

  assign idx = tcdm_slv.add[AW+1:2];
  assign oor = (tcdm_slv.add[31:AW+2] != '0) || (tcdm_slv.add[1:0] != 2'b00);

`ifdef MAC_TCDM_RESP_RANDOM_STALL_EN
  localparam logic [STALL_W:0] EXTRA_MAX = (STALL_W+1)'(3);
  logic [15:0] lfsr;

  mac_tcdm_resp_lfsr i_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (1'b1),
    .clear_i (clear_i),
    .lfsr_o  (lfsr)
  );

  // The sc >= stall+3 term caps the random extra wait even on a long run of zero LFSR bits.
  assign gnt = tcdm_slv.req && (sc_q >= stall_cycles_i) &&
               (lfsr[0] || ({1'b0, sc_q} >= ({1'b0, stall_cycles_i} + EXTRA_MAX)));
`else
  assign gnt = tcdm_slv.req && (sc_q == stall_cycles_i);
`endif

  // Clear wins over a grant in the same cycle: nothing executes or counts.
  assign acc = gnt && !clear_i;

  always_comb begin
    sc_d      = sc_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    if (clear_i) begin
      sc_d     = '0;
      r_data_d = '0;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      sc_d = (tcdm_slv.req && !gnt) ? sc_q + 1'b1 : '0;
      if (gnt) begin
        r_valid_d = 1'b1;
        err_d     = err_q | oor;
        if (tcdm_slv.wen) begin
          r_data_d = oor ? MAC_TCDM_RESP_ERR_DATA : mem_q[idx];
          rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 32'd1;
        end else begin
          r_data_d = '0;
          wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_q      <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      sc_q      <= sc_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && !tcdm_slv.wen && !oor) begin
      for (int k = 0; k < NBE; k++) begin
        if (tcdm_slv.be[k]) mem_q[idx][8*k +: 8] <= tcdm_slv.data[8*k +: 8];
      end
    end
  end

  assign tcdm_slv.gnt     = gnt;
  assign tcdm_slv.r_valid = r_valid_q;
  assign tcdm_slv.r_data  = r_data_q;
  assign rd_cnt_o         = rd_cnt_q;
  assign wr_cnt_o         = wr_cnt_q;
  assign err_o            = err_q;

endmodule
